// File: rtl/mem_pkg.sv
// Shared memory-system definitions used by the 8008 core, the RAM access
// controller and the block RAM wrapper.
package mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    HOLD,
    READ_WAIT,
    DONE,
    CLEAR
  } state_t;

  localparam logic [7:0] UNMAPPED_READ_VALUE = 8'hff;

  localparam int DEFAULT_ADDRESS_WIDTH = 14;
  localparam int DEFAULT_RAM_DEPTH     = 2048;

endpackage

// File: rtl/ram_access_ctrl.sv
// Single-outstanding-request bus initiator between the 8008 memory cycle logic
// and block RAM. Optional power-on RAM sweep is enabled with `define RAM_CLEAR_EN.
module ram_access_ctrl
  import mem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
  parameter int RAM_DEPTH     = DEFAULT_RAM_DEPTH,
  parameter int READ_LATENCY  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cpu_req,
  input  logic                     cpu_write,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address,
  input  logic [7:0]               cpu_data_in,
  output logic [7:0]               cpu_data_out,
  output logic                     cpu_ready,
  output logic                     busy,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic [7:0]               ram_data_out,
  input  logic [7:0]               ram_data_in,
  output logic                     ram_write_enable
);

  localparam logic [ADDRESS_WIDTH:0] DEPTH_LIMIT = RAM_DEPTH[ADDRESS_WIDTH:0];
  // The wait counter is loaded at the accepting edge, so it sits one above the
  // "latency minus one" value during the first READ_WAIT cycle.
  localparam logic [2:0] WAIT_LOAD = 3'(READ_LATENCY);

  state_t                   state_q, state_d;
  logic [2:0]               wait_q, wait_d;
  logic [7:0]               cpu_data_out_d;
  logic                     cpu_ready_d;
  logic                     busy_d;
  logic [ADDRESS_WIDTH-1:0] ram_address_d;
  logic [7:0]               ram_data_out_d;
  logic                     ram_write_enable_d;
  logic                     addr_mapped;

`ifdef RAM_CLEAR_EN
  logic [ADDRESS_WIDTH:0]   sweep_q, sweep_d;
`endif

  assign addr_mapped = ({1'b0, cpu_address} < DEPTH_LIMIT);

  always_comb begin
    state_d            = state_q;
    wait_d             = wait_q;
    cpu_data_out_d     = cpu_data_out;
    ram_address_d      = ram_address;
    ram_data_out_d     = ram_data_out;
    ram_write_enable_d = 1'b0;
`ifdef RAM_CLEAR_EN
    sweep_d            = sweep_q;
`endif

    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          ram_address_d  = cpu_address;
          ram_data_out_d = cpu_data_in;
          if (!addr_mapped) begin
            state_d = DONE;
            if (!cpu_write) cpu_data_out_d = UNMAPPED_READ_VALUE;
          end else if (cpu_write) begin
            state_d            = WRITE;
            ram_write_enable_d = 1'b1;
          end else begin
            state_d = READ_WAIT;
            wait_d  = WAIT_LOAD;
          end
        end
      end
      WRITE:     state_d = HOLD;
      HOLD:      state_d = DONE;
      READ_WAIT: begin
        if (wait_q == 3'd0) begin
          cpu_data_out_d = ram_data_in;
          state_d        = DONE;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      DONE:      state_d = IDLE;
`ifdef RAM_CLEAR_EN
      // One zero write per cycle; leave once the last populated byte is done.
      CLEAR: begin
        if (sweep_q < DEPTH_LIMIT) begin
          ram_address_d      = sweep_q[ADDRESS_WIDTH-1:0];
          ram_data_out_d     = 8'h00;
          ram_write_enable_d = 1'b1;
          sweep_d            = sweep_q + (ADDRESS_WIDTH+1)'(1);
        end else begin
          state_d = IDLE;
        end
      end
`else
      CLEAR:     state_d = IDLE;
`endif
      default:   state_d = IDLE;
    endcase

    cpu_ready_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
`ifdef RAM_CLEAR_EN
      state_q <= CLEAR;
      busy    <= 1'b1;
      sweep_q <= '0;
`else
      state_q <= IDLE;
      busy    <= 1'b0;
`endif
      wait_q           <= '0;
      cpu_data_out     <= 8'h00;
      cpu_ready        <= 1'b0;
      ram_address      <= '0;
      ram_data_out     <= 8'h00;
      ram_write_enable <= 1'b0;
    end else begin
`ifdef RAM_CLEAR_EN
      sweep_q <= sweep_d;
`endif
      state_q          <= state_d;
      busy             <= busy_d;
      wait_q           <= wait_d;
      cpu_data_out     <= cpu_data_out_d;
      cpu_ready        <= cpu_ready_d;
      ram_address      <= ram_address_d;
      ram_data_out     <= ram_data_out_d;
      ram_write_enable <= ram_write_enable_d;
    end
  end

endmodule
